// File: rtl/instr_feed_fifo_if.sv
// ---------------------------------------------------------------------------
// instr_feed_fifo_if
// Producer-side valid/ready handshake into the instruction feed FIFO.
//   in_valid  producer has a word on in_instr
//   in_instr  encoded instruction word, [15:12] = opcode
//   in_ready  FIFO can accept a word this edge
// Modports:
//   master  producer (drives valid/instr, observes ready)
//   slave   FIFO     (observes valid/instr, drives ready)
// ---------------------------------------------------------------------------
interface instr_feed_fifo_if;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;

  modport master (
    output in_valid,
    output in_instr,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready
  );
endinterface

// File: rtl/instr_feed_fifo.sv
// ---------------------------------------------------------------------------
// instr_feed_fifo
// Instruction-issue buffer in front of the CPU Din port. Words arrive over a
// valid/ready handshake and are released one per CPU done edge; when nothing
// is buffered a NOP word is issued instead and a starve pulse is raised.
// Ports:
//   clk          system clock, all state on posedge
//   reset        asynchronous, active-low
//   prod         producer handshake (in_valid, in_instr, in_ready)
//   flush        synchronous clear of buffered words (Din kept)
//   done         CPU ready for the next instruction
//   Din          registered instruction to CPU
//   issue        1-cycle pulse, Din loaded from the FIFO head this edge
//   starved      1-cycle pulse, done seen while empty, NOP issued
//   level        occupancy 0..DEPTH
//   issue_count  number of real issues, wraps
// ---------------------------------------------------------------------------
module instr_feed_fifo #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_feed_fifo_if.slave         prod,
  input  logic                     flush,
  input  logic                     done,
  output logic [15:0]              Din,
  output logic                     issue,
  output logic                     starved,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issue_count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]  wr_ptr_r;
  logic [AW:0]  rd_ptr_r;
  logic [15:0]  mem_r [DEPTH];
  logic [15:0]  din_r;
  logic         issue_r;
  logic         starved_r;
  logic [15:0]  issue_count_r;

  logic         empty_s;
  logic         full_s;
  logic         push_s;
  logic         pop_s;
  logic         starve_s;

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  // Ready depends on registered state and reset only, never on done.
  assign prod.in_ready = !full_s && reset;

  assign level       = wr_ptr_r - rd_ptr_r;
  assign Din         = din_r;
  assign issue       = issue_r;
  assign starved     = starved_r;
  assign issue_count = issue_count_r;

  // Per-edge push/pop/starve decisions; flush wins over both push and pop.
  always_comb begin
    push_s   = 1'b0;
    pop_s    = 1'b0;
    starve_s = 1'b0;
    if (flush) begin
      starve_s = done;
    end else begin
      push_s   = prod.in_valid && prod.in_ready;
      pop_s    = done && !empty_s;
      starve_s = done && empty_s;
    end
  end

  // Storage array; only written on an accepted push, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= prod.in_instr;
    end
  end

  // Read/write pointers, cleared by reset and by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // CPU-side outputs: Din, issue/starve pulses and the issue counter.
  // Din survives flush; it only changes when the CPU asks for a word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      din_r         <= NOP_WORD;
      issue_r       <= 1'b0;
      starved_r     <= 1'b0;
      issue_count_r <= 16'h0000;
    end else begin
      issue_r   <= pop_s;
      starved_r <= starve_s;
      if (pop_s) begin
        din_r         <= mem_r[rd_ptr_r[AW-1:0]];
        issue_count_r <= issue_count_r + 16'h0001;
      end else if (starve_s) begin
        din_r <= NOP_WORD;
      end
    end
  end

endmodule

// File: tb/tb_instr_feed_fifo.sv
// ---------------------------------------------------------------------------
// tb_instr_feed_fifo
// Scoreboard bench: a queue-based reference model updates on each posedge and
// pushes the expected Din/pulse for every done edge; a negedge monitor pops
// and compares whenever the DUT shows issue or starved, and also compares
// level, in_ready, issue_count and Din against the model every cycle.
// ---------------------------------------------------------------------------
module tb_instr_feed_fifo;

  localparam int          DEPTH = 8;
  localparam logic [15:0] NOP   = 16'h0000;

  typedef struct {
    bit          is_issue;
    logic [15:0] word;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        done;
  logic [15:0] Din;
  logic        issue;
  logic        starved;
  logic [3:0]  level;
  logic [15:0] issue_count;

  instr_feed_fifo_if pif ();

  instr_feed_fifo #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .prod        (pif.slave),
    .flush       (flush),
    .done        (done),
    .Din         (Din),
    .issue       (issue),
    .starved     (starved),
    .level       (level),
    .issue_count (issue_count)
  );

  int          checks   = 0;
  int          failures = 0;

  logic [15:0] m_q [$];
  exp_t        exp_q [$];
  logic [15:0] m_din = NOP;
  logic [15:0] m_cnt = 16'h0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: a plain queue of buffered words.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      exp_q.delete();
      m_din = NOP;
      m_cnt = 16'h0000;
    end else begin
      bit acc;
      exp_t e;
      acc = pif.in_valid && (m_q.size() < DEPTH);
      if (flush) begin
        m_q.delete();
        if (done) begin
          e.is_issue = 1'b0; e.word = NOP;
          exp_q.push_back(e);
          m_din = NOP;
        end
      end else begin
        if (done) begin
          if (m_q.size() == 0) begin
            e.is_issue = 1'b0; e.word = NOP;
          end else begin
            e.is_issue = 1'b1; e.word = m_q.pop_front();
            m_cnt = m_cnt + 16'h0001;
          end
          m_din = e.word;
          exp_q.push_back(e);
        end
        if (acc) m_q.push_back(pif.in_instr);
      end
    end
  end

  // Monitor: compare DUT outputs to the model away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      if (issue || starved) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {issue, starved}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {30'h0, issue, starved}, e.is_issue ? 32'h2 : 32'h1);
          chk("din_on_pulse", Din, e.word);
        end
      end
      chk("missing_pulse", exp_q.size(), 0);
      chk("level", level, m_q.size());
      chk("in_ready", pif.in_ready, (m_q.size() < DEPTH) ? 1 : 0);
      chk("issue_count", issue_count, m_cnt);
      chk("din_hold", Din, m_din);
    end
  end

  task automatic drive(input bit v, input logic [15:0] w, input bit d, input bit f);
    @(negedge clk);
    #1;
    pif.in_valid = v;
    pif.in_instr = w;
    done         = d;
    flush        = f;
  endtask

  initial begin
    reset        = 1'b0;
    pif.in_valid = 1'b0;
    pif.in_instr = 16'h0000;
    done         = 1'b0;
    flush        = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    chk("reset_din", Din, 16'h0000);
    chk("reset_level", level, 0);

    // Ordering
    drive(1'b1, 16'h1234, 1'b0, 1'b0);
    drive(1'b1, 16'h5678, 1'b0, 1'b0);
    drive(1'b1, 16'h9ABC, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("order_last_din", Din, 16'h9ABC);
    chk("order_count", issue_count, 16'd3);
    chk("order_level", level, 0);

    // Starve on empty
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("starve_din", Din, NOP);
    chk("starve_count", issue_count, 16'd3);

    // Simultaneous push and pop while empty: NOP first, then the word
    drive(1'b1, 16'hA001, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("simul_level", level, 1);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("simul_din", Din, 16'hA001);

    // Full
    for (int i = 0; i < 8; i++) drive(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0);
    drive(1'b1, 16'h3008, 1'b0, 1'b0);
    chk("full_level", level, 8);
    chk("full_ready", pif.in_ready, 1'b0);
    drive(1'b1, 16'h3008, 1'b1, 1'b0);
    chk("full_refused", level, 8);
    drive(1'b1, 16'h3008, 1'b0, 1'b0);
    chk("full_after_pop", level, 7);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_accept", level, 8);
    repeat (8) drive(1'b0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("full_drain_din", Din, 16'h3008);

    // Wrap pointers, then flush with level 4
    for (int i = 0; i < 20; i++) drive(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    chk("wrap_last_din", Din, 16'h2013);
    chk("preflush_level", level, 4);
    drive(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("flush_level", level, 0);
    chk("flush_din_kept", Din, 16'h2013);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("flush_then_nop", Din, NOP);

    // Randomized traffic with occasional flush
    for (int i = 0; i < 800; i++) begin
      bit d;
      d = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 2) != 0, 16'($urandom), d, $urandom_range(0, 40) == 0);
    end

    // Reset mid-run with level 5
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b1, 16'h5000 + 16'(i), 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("pre_reset_level", level, 5);
    #2 reset = 1'b0;
    #1;
    chk("midrst_din", Din, 16'h0000);
    chk("midrst_level", level, 0);
    chk("midrst_ready", pif.in_ready, 1'b0);
    chk("midrst_issue", issue, 1'b0);
    chk("midrst_starved", starved, 1'b0);
    chk("midrst_count", issue_count, 16'h0000);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 100; i++)
      drive($urandom_range(0, 1) != 0, 16'($urandom), $urandom_range(0, 1) != 0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    chk("final_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
